// File: rtl/swreg_delay_trigger_if.sv
// Bundle between the software-register block and the delay/trigger block.
// The user_clk clock and the user_rst_n reset are not part of the bundle.
//   master : the register source and sync source. It drives user_data_in and
//            sync_in, and it observes the trigger and status outputs.
//   slave  : the trigger block (swreg_delay_trigger).
// Fields:
//   user_data_in : 32-bit software register value
//                  (bit31 arm, bit30 continuous, low bits delay).
//   sync_in      : external sync level.
//   trig_out     : one-cycle trigger pulse.
//   armed        : high in the ARMED state.
//   busy         : high in the COUNT state.
//   reg_q        : the register value that has been accepted.
//   trig_cnt     : number of triggers issued.
//   overrun_cnt  : number of sync edges ignored while counting.
interface swreg_delay_trigger_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      user_data_in;
  logic             sync_in;
  logic             trig_out;
  logic             armed;
  logic             busy;
  logic [31:0]      reg_q;
  logic [CNT_W-1:0] trig_cnt;
  logic [7:0]       overrun_cnt;

  modport master (
    output user_data_in, sync_in,
    input  trig_out, armed, busy, reg_q, trig_cnt, overrun_cnt
  );

  modport slave (
    input  user_data_in, sync_in,
    output trig_out, armed, busy, reg_q, trig_cnt, overrun_cnt
  );
endinterface

// File: rtl/swreg_delay_trigger.sv
// Programmable delayed trigger, driven by a software register.
//
// The block first qualifies the incoming register value against tearing.
// A value is accepted only after it has been held for STABLE_CYCLES
// consecutive identical samples.
//
// From the accepted value, the block takes three fields:
//   bit 31            : arm
//   bit 30            : continuous
//   bits [DELAY_W-1:0]: delay D
//
// Behaviour:
//   - A rising edge of the arm bit arms the block.
//   - When armed, a rising edge on sync_in starts a countdown.
//   - trig_out then pulses D+1 cycles after that sync edge.
//
// Ports:
//   user_clk   : the only clock.
//   user_rst_n : asynchronous, active-low reset.
//   bus        : slave side of swreg_delay_trigger_if.
module swreg_delay_trigger #(
  parameter int DELAY_W       = 16,
  parameter int STABLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic                 user_clk,
  input  logic                 user_rst_n,
  swreg_delay_trigger_if.slave bus
);

  localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, COUNT} state_t;

  state_t             state;
  logic [31:0]        data_prev;
  logic [3:0]         run;
  logic [31:0]        reg_q;
  logic               arm_q;
  logic               sync_q;
  logic [DELAY_W-1:0] dly_cnt;
  logic               trig;
  logic [CNT_W-1:0]   trig_cnt;
  logic [7:0]         ovr_cnt;

  logic arm_rise, arm_fall, sync_rise;

  // Stability qualifier.
  // run counts consecutive identical samples. At RUN_MAX it holds, and
  // reg_q keeps reloading the same value. Any change to the input restarts
  // the count, so a value that toggles every cycle never reaches reg_q.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      data_prev <= '0;
      run       <= '0;
      reg_q     <= '0;
    end else begin
      data_prev <= bus.user_data_in;
      if (bus.user_data_in != data_prev) begin
        run <= '0;
      end else if (run != RUN_MAX) begin
        run <= run + 4'd1;
      end else begin
        reg_q <= bus.user_data_in;
      end
    end
  end

  // Edge-detect registers for the arm bit and for sync_in.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      arm_q  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      arm_q  <= reg_q[31];
      sync_q <= bus.sync_in;
    end
  end

  assign arm_rise  =  reg_q[31] & ~arm_q;
  assign arm_fall  = ~reg_q[31] &  arm_q;
  assign sync_rise =  bus.sync_in & ~sync_q;

  // Control FSM.
  // The delay is captured into dly_cnt when COUNT is entered, so later
  // writes to the register do not disturb a count in progress.
  // trig is a one-cycle pulse: its default is 0 in every cycle.
  // COUNT is always left on the cycle that fires, so two triggers are
  // never issued back to back.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state    <= IDLE;
      dly_cnt  <= '0;
      trig     <= 1'b0;
      trig_cnt <= '0;
      ovr_cnt  <= '0;
    end else begin
      trig <= 1'b0;
      case (state)
        IDLE: begin
          if (arm_rise) state <= ARMED;
        end

        // When arm_fall and sync_rise arrive together, disarming wins.
        ARMED: begin
          if (arm_fall) begin
            state <= IDLE;
          end else if (sync_rise) begin
            state   <= COUNT;
            dly_cnt <= reg_q[DELAY_W-1:0];
          end
        end

        COUNT: begin
          if (sync_rise && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
          if (arm_fall) begin
            state <= IDLE;
          end else if (dly_cnt != '0) begin
            dly_cnt <= dly_cnt - 1'b1;
          end else begin
            trig     <= 1'b1;
            trig_cnt <= trig_cnt + 1'b1;
            state    <= reg_q[30] ? ARMED : IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.trig_out    = trig;
  assign bus.armed       = (state == ARMED);
  assign bus.busy        = (state == COUNT);
  assign bus.reg_q       = reg_q;
  assign bus.trig_cnt    = trig_cnt;
  assign bus.overrun_cnt = ovr_cnt;

endmodule

// File: tb/tb_swreg_delay_trigger.sv
// Directed testbench for swreg_delay_trigger.
// The bench sets inputs and samples outputs 1 time unit after each rising
// edge of user_clk.
// Timing reference: sync_in is set just after an edge. Step 1 is the next
// edge, where sync_in is sampled. A delay of D therefore makes trig_out
// visible after step D+2, which is D+1 cycles after the sampling edge.
module tb_swreg_delay_trigger;

  logic user_clk = 1'b0;
  logic user_rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 user_clk = ~user_clk;

  swreg_delay_trigger_if #(.CNT_W(16)) bus ();

  swreg_delay_trigger #(
    .DELAY_W(16), .STABLE_CYCLES(2), .CNT_W(16)
  ) dut (
    .user_clk  (user_clk),
    .user_rst_n(user_rst_n),
    .bus       (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge user_clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " reg_q"},    bus.reg_q, 32'h0);
    chk({tag, " trig_cnt"}, 32'(bus.trig_cnt), 32'h0);
    chk({tag, " overrun"},  32'(bus.overrun_cnt), 32'h0);
    chk({tag, " trig"},     32'(bus.trig_out), 32'h0);
    chk({tag, " armed"},    32'(bus.armed), 32'h0);
    chk({tag, " busy"},     32'(bus.busy), 32'h0);
  endtask

  task automatic do_reset();
    bus.user_data_in = 32'h0;
    bus.sync_in      = 1'b0;
    user_rst_n       = 1'b0;
    step(2);
    user_rst_n = 1'b1;
    step(4);
  endtask

  int first, pulses, bad;

  initial begin
    bus.user_data_in = 32'h0;
    bus.sync_in      = 1'b0;
    user_rst_n       = 1'b0;
    #12;
    chk_zero("rst");
    step(1);
    user_rst_n = 1'b1;
    step(4);

    // Single shot, D=5.
    bus.user_data_in = 32'h8000_0005;
    step(2);
    chk("t1 reg_q early", bus.reg_q, 32'h0);
    step(1);
    chk("t1 reg_q", bus.reg_q, 32'h8000_0005);
    chk("t1 not armed yet", 32'(bus.armed), 32'h0);
    step(1);
    chk("t1 armed", 32'(bus.armed), 32'h1);
    bus.sync_in = 1'b1;
    first = 0; pulses = 0;
    for (int i = 1; i <= 14; i++) begin
      step(1);
      if (bus.trig_out) begin pulses++; if (first == 0) first = i; end
    end
    bus.sync_in = 1'b0;
    chk("t1 trig step", 32'(first), 32'd7);
    chk("t1 pulses", 32'(pulses), 32'd1);
    chk("t1 trig_cnt", 32'(bus.trig_cnt), 32'd1);
    chk("t1 idle", 32'(bus.armed), 32'h0);
    chk("t1 not busy", 32'(bus.busy), 32'h0);

    // An input that toggles every cycle must never be accepted.
    do_reset();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.user_data_in = (i % 2 == 0) ? 32'h8000_0001 : 32'h0;
      step(1);
      if (bus.armed || bus.reg_q != 32'h0) bad++;
    end
    chk("t2 reg_q", bus.reg_q, 32'h0);
    chk("t2 armed", 32'(bus.armed), 32'h0);
    chk("t2 bad cycles", 32'(bad), 32'h0);

    // Continuous mode, D=0, four sync pulses spaced 4 cycles apart.
    do_reset();
    bus.user_data_in = 32'hC000_0000;
    step(4);
    chk("t3 armed", 32'(bus.armed), 32'h1);
    pulses = 0; bad = 0;
    for (int p = 0; p < 4; p++) begin
      bus.sync_in = 1'b1;
      step(1);
      if (bus.trig_out) bad++;
      step(1);
      if (bus.trig_out) pulses++;
      bus.sync_in = 1'b0;
      step(1);
      if (bus.trig_out || !bus.armed) bad++;
      step(1);
      if (bus.trig_out || !bus.armed) bad++;
    end
    chk("t3 pulses", 32'(pulses), 32'd4);
    chk("t3 bad cycles", 32'(bad), 32'd0);
    chk("t3 trig_cnt", 32'(bus.trig_cnt), 32'd4);

    // Continuous mode, D=10, second sync edge 3 cycles after the first.
    do_reset();
    bus.user_data_in = 32'hC000_000A;
    step(4);
    bus.sync_in = 1'b1;
    first = 0; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (bus.trig_out) begin pulses++; if (first == 0) first = i; end
      bus.sync_in = (i == 3);
    end
    chk("t4 trig step", 32'(first), 32'd12);
    chk("t4 pulses", 32'(pulses), 32'd1);
    chk("t4 overrun", 32'(bus.overrun_cnt), 32'd1);
    chk("t4 trig_cnt", 32'(bus.trig_cnt), 32'd1);
    chk("t4 rearmed", 32'(bus.armed), 32'd1);

    // Clearing arm in the middle of a count aborts it.
    do_reset();
    bus.user_data_in = 32'h8000_0064;
    step(4);
    bus.sync_in = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 120; i++) begin
      step(1);
      if (bus.trig_out) pulses++;
      if (i == 2)  chk("t5 busy", 32'(bus.busy), 32'd1);
      if (i == 10) bus.user_data_in = 32'h0000_0064;
      if (i == 13) chk("t5 busy before fall", 32'(bus.busy), 32'd1);
      if (i == 14) chk("t5 busy dropped", 32'(bus.busy), 32'd0);
    end
    bus.sync_in = 1'b0;
    chk("t5 pulses", 32'(pulses), 32'd0);
    chk("t5 armed", 32'(bus.armed), 32'd0);
    chk("t5 trig_cnt", 32'(bus.trig_cnt), 32'd0);

    // Asynchronous reset in the middle of a count.
    do_reset();
    bus.user_data_in = 32'h8000_0005;
    step(4);
    bus.sync_in = 1'b1;
    step(3);
    chk("t6 busy", 32'(bus.busy), 32'd1);
    #2;
    user_rst_n       = 1'b0;
    bus.sync_in      = 1'b0;
    bus.user_data_in = 32'h0;
    #1;
    chk_zero("t6 async");
    step(1);
    user_rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.trig_out) pulses++;
    end
    chk("t6 pulses", 32'(pulses), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
